// File: rtl/reg_file_wb.sv
// reg_file_wb: 2**ADDR_W x DATA_W register file for the single-cycle MIPS datapath.
// Two asynchronous read ports (rs/rt), one synchronous write port, a debug read
// port and a committed-write counter. Register 0 reads as zero.
// Optional macro REGFILE_BYPASS_EN: write-through bypass on rdata_a/rdata_b.
module reg_file_wb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] r_addr_a,
   input  logic [ADDR_W-1:0] r_addr_b,
   input  logic [ADDR_W-1:0] wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   input  logic              we,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              commit;

   // A write commits only outside reset and never to register 0
   assign commit = we && !rst && (wt_addr != '0);

   // Array update and write counter; reset clears every entry and drops any write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_count <= '0;
      end else if (commit) begin
         mem[wt_addr] <= wt_data;
         wr_count     <= wr_count + 1'b1;
      end
   end

   // Combinational read ports; address 0 is forced to zero on every port
   always_comb begin
      rdata_a  = (r_addr_a == '0) ? '0 : mem[r_addr_a];
      rdata_b  = (r_addr_b == '0) ? '0 : mem[r_addr_b];
      dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
`ifdef REGFILE_BYPASS_EN
      // commit already excludes address 0, so the bypass cannot break the zero register
      if (commit && (r_addr_a == wt_addr)) rdata_a = wt_data;
      if (commit && (r_addr_b == wt_addr)) rdata_b = wt_data;
`endif
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: scoreboard bench for reg_file_wb. The driver pushes the expected
// outputs of each cycle into a queue; a monitor on the falling edge pops and compares.
// Honours REGFILE_BYPASS_EN when defined. Counter is built narrow to exercise wrap.
module tb_reg_file_wb;

   localparam int unsigned CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  r_addr_a, r_addr_b, wt_addr, dbg_addr;
   logic [31:0] wt_data;
   logic        we;
   logic [31:0] rdata_a, rdata_b, dbg_data;
   logic [CNT_W-1:0] wr_count;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      d;
      logic [CNT_W-1:0] c;
   } exp_t;

   exp_t q[$];

   // Reference model: plain array of register values plus an integer write count
   logic [31:0] model [32];
   int unsigned cnt;

   reg_file_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .r_addr_a (r_addr_a),
      .r_addr_b (r_addr_b),
      .wt_addr  (wt_addr),
      .wt_data  (wt_data),
      .we       (we),
      .rdata_a  (rdata_a),
      .rdata_b  (rdata_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd(input logic [4:0] addr);
      return (addr == 5'd0) ? 32'd0 : model[addr];
   endfunction

   function automatic void cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   // One clock cycle of stimulus: drive, predict, push, then advance the model past the edge
   task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
      exp_t e;
      rst = r; we = w; wt_addr = wa; wt_data = wd;
      r_addr_a = ra; r_addr_b = rb; dbg_addr = da;
      e.a = rd(ra);
      e.b = rd(rb);
      e.d = rd(da);
`ifdef REGFILE_BYPASS_EN
      if (w && !r && wa != 5'd0 && ra == wa) e.a = wd;
      if (w && !r && wa != 5'd0 && rb == wa) e.b = wd;
`endif
      e.c = CNT_W'(cnt);
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
         cnt = 0;
      end else if (w && wa != 5'd0) begin
         model[wa] = wd;
         cnt = (cnt + 1) % (2 ** CNT_W);
      end
      #1;
   endtask

   // Monitor: outputs are stable mid-cycle; compare against the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         cmp("rdata_a", rdata_a, e.a);
         cmp("rdata_b", rdata_b, e.b);
         cmp("dbg_data", dbg_data, e.d);
         cmp("wr_count", 32'(wr_count), 32'(e.c));
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      cnt = 0;
      // Unchecked initial reset: array contents are unknown before it
      rst = 1'b1; we = 1'b0; wt_addr = '0; wt_data = '0;
      r_addr_a = '0; r_addr_b = '0; dbg_addr = '0;
      @(posedge clk); #1;

      // Reset clear with a write presented in the reset cycle
      step(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
      step(1, 1, 5'd5, 32'h12345678, 5'd5, 5'd5, 5'd5);
      step(0, 0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5);

      // Basic write/read
      step(0, 1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
      step(0, 1, 5'd1,  32'h00000001, 5'd31, 5'd1, 5'd31);
      step(0, 0, 5'd0,  32'h0,        5'd31, 5'd1, 5'd31);

      // Register 0 write attempt
      step(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      step(0, 0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0);

      // Same-cycle read of a register being rewritten
      step(0, 1, 5'd7, 32'h11111111, 5'd7, 5'd7, 5'd7);
      step(0, 1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7);
      step(0, 0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd7);

      // we low
      step(0, 0, 5'd3, 32'h00000055, 5'd3, 5'd3, 5'd3);
      step(0, 0, 5'd0, 32'h0,        5'd3, 5'd3, 5'd3);

      // Counter wrap: 17 writes to reg2 after reset, including an unchanged-data write
      step(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 5'd2, 32'h5, 5'd2, 5'd2, 5'd2);
      step(0, 1, 5'd2, 32'h5, 5'd2, 5'd2, 5'd2);
      for (int i = 0; i < 15; i++) step(0, 1, 5'd2, 32'h100 + i, 5'd2, 5'd0, 5'd2);
      step(0, 0, 5'd0, 32'h0, 5'd2, 5'd2, 5'd2);

      // Randomized traffic; small address pool for frequent collisions
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa, ra, rb, da;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         ra = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
         rb = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
         da = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom);
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), wa, $urandom, ra, rb, da);
      end
      step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

      // Every prediction must have been consumed by the monitor
      @(negedge clk); #1;
      cmp("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit 2:1 write-register select mux (rt/rd select); that mux output drives wt_addr.
- Provides two asynchronous read ports for the decode/ALU stage and one synchronous write port.
- Adds a debug read port and a committed-write counter for the board display.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- r_addr_a  in  ADDR_W  read port A address (rs).
- r_addr_b  in  ADDR_W  read port B address (rt).
- wt_addr  in  ADDR_W  write address, from the write-register select mux output.
- wt_data  in  DATA_W  write-back data (ALU result or memory load).
- we  in  1  write enable (RegWrite).
- rdata_a  out  DATA_W  read port A data.
- rdata_b  out  DATA_W  read port B data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data.
- wr_count  out  CNT_W  number of committed writes since reset.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: on a rising edge with rst=1, all 32 registers are cleared to 0 and wr_count is cleared to 0. Any we/wt_addr/wt_data presented in that cycle is ignored.
- Write:
  - On a rising edge with rst=0, we=1 and wt_addr!=0, reg[wt_addr] <= wt_data and wr_count <= wr_count+1.
  - When wt_addr=0, or we=0, no register changes and wr_count holds.
- Register 0:
  - Hardwired to 0 and never stored.
  - Any read of address 0 on any port returns 0, regardless of prior write attempts.
- Reads:
  - rdata_a, rdata_b and dbg_data are combinational functions of their addresses and the current array contents; zero cycles of address-to-data latency.
  - The post-reset read value of every address is 0.
- Write/read same cycle (without the optional feature): reads return the old contents during the write cycle; the new value is visible only after the rising edge.
- wr_count:
  - Wraps from 2**CNT_W-1 to 0 with no saturation or flag.
  - Increments on writes where the data is unchanged (e.g. writing 5 over 5).
  - Never increments on writes to address 0.
- Simultaneous events:
  - Two read ports and the debug port may address the same register; all return identical data.
  - rst=1 and we=1 together: reset wins.
- Reset mid-operation: a write in progress is dropped. The register keeps no partial state; it reads 0 after the edge.
- No X propagation: every output is defined for every address value.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: write-through bypass on rdata_a and rdata_b. If we=1, rst=0, wt_addr!=0 and r_addr_x==wt_addr, then rdata_x=wt_data combinationally in the same cycle. dbg_data is not bypassed. Address 0 still reads 0.
- When undefined: no bypass; the same-cycle read returns the old value, as described under Behaviour.

Test Plan:
- Reset clear: preload reg5=0xDEADBEEF, assert rst one cycle with we=1, wt_addr=5, wt_data=0x12345678 -> rdata_a(r_addr_a=5)=0, wr_count=0.
- Basic write/read: write reg31=0xA5A5A5A5, then reg1=0x00000001 -> r_addr_a=31 gives 0xA5A5A5A5, r_addr_b=1 gives 0x00000001, dbg_addr=31 gives 0xA5A5A5A5, wr_count=2.
- Register 0: we=1, wt_addr=0, wt_data=0xFFFFFFFF -> rdata_a(addr 0)=0 after the edge; wr_count unchanged.
- Same-cycle read, write reg7=0x11111111 then reg7=0x22222222 with r_addr_a=7:
  - Without REGFILE_BYPASS_EN: rdata_a reads 0x11111111 during the second write cycle and 0x22222222 after the edge.
  - With REGFILE_BYPASS_EN: rdata_a reads 0x22222222 during the second write cycle.
- we low: we=0, wt_addr=3, wt_data=0x55 -> reg3 stays 0, wr_count holds.
- Counter wrap: with CNT_W=4, perform 17 writes to reg2 -> wr_count=1; reg2 holds the last written value.
